// File: rtl/prog_loader.sv
// prog_loader: streams a program into comp's out-of-band write port while
// holding the core in reset, then releases it and times the run until halt
// or a cycle limit.
module prog_loader #(
  parameter int ADDR_W     = 8,
  parameter int MAX_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       oob_wr_addr,
  output logic [31:0]       oob_wr_data,
  output logic              oob_wen,
  output logic              cpu_rst,
  input  logic              halt,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [31:0]       run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [31:0] CYC_LIMIT = 32'(MAX_CYCLES);

  state_t          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            wen_q, wen_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic            timed_out_q, timed_out_d;
  logic [31:0]     run_cycles_q, run_cycles_d;

  logic            accept;
  logic [ADDR_W:0] cnt_inc;
  logic [31:0]     run_inc;

  // Handshake and status outputs decoded directly from state.
  always_comb begin
    in_ready = (state_q == S_LOAD);
    busy     = (state_q == S_LOAD) || (state_q == S_SETTLE) || (state_q == S_RUN);
    done     = (state_q == S_DONE);
    accept   = in_valid && (state_q == S_LOAD);
  end

  // Next-state logic: load sequencing, settle cycle and run-cycle counting.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wen_d        = 1'b0;
    cpu_rst_d    = cpu_rst_q;
    timed_out_d  = timed_out_q;
    run_cycles_d = run_cycles_q;
    cnt_inc      = cnt_q + 1'b1;
    run_inc      = run_cycles_q + 32'd1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d        = load_len;
          cnt_d        = '0;
          timed_out_d  = 1'b0;
          run_cycles_d = '0;
          cpu_rst_d    = 1'b1;
          // An empty program skips straight to the settle cycle.
          state_d      = (load_len == '0) ? S_SETTLE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wen_d  = 1'b1;
          addr_d = 32'(cnt_q);
          data_d = in_data;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        // The final write strobe lands in this cycle while comp is still in reset.
        cpu_rst_d = 1'b0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        run_cycles_d = run_inc;
        if (halt) begin
          timed_out_d = 1'b0;
          state_d     = S_DONE;
        end else if (run_inc == CYC_LIMIT) begin
          timed_out_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output flops; async reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wen_q        <= 1'b0;
      cpu_rst_q    <= 1'b1;
      timed_out_q  <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wen_q        <= wen_d;
      cpu_rst_q    <= cpu_rst_d;
      timed_out_q  <= timed_out_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign oob_wr_addr = addr_q;
  assign oob_wr_data = data_q;
  assign oob_wen     = wen_q;
  assign cpu_rst     = cpu_rst_q;
  assign timed_out   = timed_out_q;
  assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader. Stimulus pushes expected
// writes, run outcomes and point checks into queues; one negedge monitor
// compares everything the DUT presents.
module tb_prog_loader;

  localparam int ADDR_W     = 8;
  localparam int MAX_CYCLES = 100;

  localparam int ID_READY  = 0;
  localparam int ID_WEN    = 1;
  localparam int ID_ADDR   = 2;
  localparam int ID_DATA   = 3;
  localparam int ID_CPURST = 4;
  localparam int ID_BUSY   = 5;
  localparam int ID_DONE   = 6;
  localparam int ID_TO     = 7;
  localparam int ID_RC     = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0;
  logic              halt = 1'b0;
  logic              in_ready, oob_wen, cpu_rst, busy, done, timed_out;
  logic [31:0]       oob_wr_addr, oob_wr_data, run_cycles;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_CYCLES(MAX_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .oob_wr_addr(oob_wr_addr), .oob_wr_data(oob_wr_data), .oob_wen(oob_wen),
    .cpu_rst(cpu_rst), .halt(halt), .busy(busy), .done(done),
    .timed_out(timed_out), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic to; logic [31:0] rc; int cyc; } res_t;
  typedef struct { int id; logic [31:0] exp; } chk_t;

  wr_t  wr_q[$];
  res_t res_q[$];
  chk_t chk_q[$];

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   fin = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sig_name(int id);
    case (id)
      ID_READY:  return "in_ready";
      ID_WEN:    return "oob_wen";
      ID_ADDR:   return "oob_wr_addr";
      ID_DATA:   return "oob_wr_data";
      ID_CPURST: return "cpu_rst";
      ID_BUSY:   return "busy";
      ID_DONE:   return "done";
      ID_TO:     return "timed_out";
      ID_RC:     return "run_cycles";
      default:   return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] actual(int id);
    case (id)
      ID_READY:  return {31'b0, in_ready};
      ID_WEN:    return {31'b0, oob_wen};
      ID_ADDR:   return oob_wr_addr;
      ID_DATA:   return oob_wr_data;
      ID_CPURST: return {31'b0, cpu_rst};
      ID_BUSY:   return {31'b0, busy};
      ID_DONE:   return {31'b0, done};
      ID_TO:     return {31'b0, timed_out};
      ID_RC:     return run_cycles;
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic void compare(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: the only process that compares.
  chk_t mc;
  wr_t  mw;
  res_t mr;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      mc = chk_q.pop_front();
      compare(sig_name(mc.id), actual(mc.id), mc.exp);
    end
    if (oob_wen === 1'b1) begin
      if (wr_q.size() == 0) begin
        compare("unexpected_oob_wen", {31'b0, oob_wen}, 32'd0);
      end else begin
        mw = wr_q.pop_front();
        compare("write_addr", oob_wr_addr, mw.addr);
        compare("write_data", oob_wr_data, mw.data);
        compare("write_cycle", 32'(cyc), 32'(mw.cyc));
      end
    end
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (res_q.size() == 0) begin
        compare("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        mr = res_q.pop_front();
        compare("result_timed_out", {31'b0, timed_out}, {31'b0, mr.to});
        compare("result_run_cycles", run_cycles, mr.rc);
        compare("result_cycle", 32'(cyc), 32'(mr.cyc));
      end
    end
    done_prev = done;
    if (fin) begin
      compare("pending_writes", 32'(wr_q.size()), 32'd0);
      compare("pending_results", 32'(res_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(int id, logic [31:0] e);
    chk_t c;
    c.id  = id;
    c.exp = e;
    chk_q.push_back(c);
  endtask

  task automatic expect_reset_values();
    expect_sig(ID_READY, 32'd0);
    expect_sig(ID_WEN, 32'd0);
    expect_sig(ID_ADDR, 32'd0);
    expect_sig(ID_DATA, 32'd0);
    expect_sig(ID_CPURST, 32'd1);
    expect_sig(ID_BUSY, 32'd0);
    expect_sig(ID_DONE, 32'd0);
    expect_sig(ID_TO, 32'd0);
    expect_sig(ID_RC, 32'd0);
  endtask

  task automatic push_wr(int idx, logic [31:0] d);
    wr_t w;
    w.addr = 32'(idx);
    w.data = d;
    w.cyc  = cyc + 1;
    wr_q.push_back(w);
  endtask

  // mode 0: valid every cycle, 1: valid toggles 1,0,1,0..., 2: random valid and data.
  task automatic do_load(int len, int mode);
    int          i;
    bit          tog;
    bit          v;
    logic [31:0] w;
    int          ll;
    ll       = len;
    load_len = ll[ADDR_W:0];
    start    = 1'b1;
    tick();
    start = 1'b0;
    expect_sig(ID_DONE, 32'd0);
    expect_sig(ID_TO, 32'd0);
    expect_sig(ID_RC, 32'd0);
    expect_sig(ID_CPURST, 32'd1);
    i   = 0;
    tog = 1'b1;
    while (i < len) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      expect_sig(ID_READY, 32'd1);
      in_valid = v;
      if (v) begin
        w       = (mode == 2) ? $urandom : (32'hA0 + 32'(i));
        in_data = w;
        push_wr(i, w);
        i++;
      end else begin
        in_data = $urandom;
      end
      tick();
    end
    // Settle cycle: stray valids here must be ignored.
    in_valid = 1'($urandom_range(0, 1));
    in_data  = $urandom;
    expect_sig(ID_READY, 32'd0);
    expect_sig(ID_CPURST, 32'd1);
    expect_sig(ID_BUSY, 32'd1);
    expect_sig(ID_DONE, 32'd0);
    tick();
    in_valid = 1'b0;
    expect_sig(ID_CPURST, 32'd0);
    expect_sig(ID_BUSY, 32'd1);
  endtask

  // Called in the first RUN cycle. h = RUN cycle on which halt is high (0 = never).
  task automatic do_run(int h, int start_at);
    int   n;
    int   rc;
    bit   to;
    res_t r;
    if (h >= 1 && h <= MAX_CYCLES) begin
      rc = h;
      to = 1'b0;
    end else begin
      rc = MAX_CYCLES;
      to = 1'b1;
    end
    r.to  = to;
    r.rc  = 32'(rc);
    r.cyc = cyc + rc;
    res_q.push_back(r);
    n = 1;
    while (done !== 1'b1 && n <= MAX_CYCLES + 5) begin
      halt  = (n == h);
      start = (n == start_at);
      if (start) load_len = 9'd3;
      tick();
      n++;
    end
    halt  = 1'b0;
    start = 1'b0;
    expect_sig(ID_DONE, 32'd1);
    expect_sig(ID_CPURST, 32'd0);
    expect_sig(ID_TO, {31'b0, to});
    tick();
    tick();
    expect_sig(ID_RC, 32'(rc));
    expect_sig(ID_DONE, 32'd1);
    expect_sig(ID_BUSY, 32'd0);
  endtask

  initial begin
    // Reset state, checked while rst is held low.
    #1;
    expect_reset_values();
    #20;
    rst = 1'b1;
    tick();

    do_load(4, 0);
    do_run(7, 0);

    do_load(4, 1);
    do_run(0, 0);

    do_load(4, 2);
    do_run(100, 0);

    do_load(0, 0);
    do_run(20, 5);

    do_load(256, 0);
    do_run(1, 0);

    // Async reset in the middle of a load.
    load_len = 9'd5;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hB0;
    push_wr(0, 32'hB0);
    tick();
    in_data = 32'hB1;
    push_wr(1, 32'hB1);
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    rst = 1'b0;
    expect_reset_values();
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    do_load(3, 0);
    do_run($urandom_range(1, 120), 0);

    for (int k = 0; k < 6; k++) begin
      do_load($urandom_range(0, 12), $urandom_range(0, 2));
      do_run($urandom_range(0, 110), $urandom_range(0, 30));
    end

    tick();
    tick();
    fin = 1'b1;
    @(negedge clk);
    #1;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Synthesizable replacement for the bench-side program load and run sequence in front of `comp`. Accepts a stream of 32-bit program words over a valid/ready handshake and writes them into `comp`'s out-of-band write port at consecutive addresses from 0, holding the core in reset throughout. It then releases the core, counts run cycles until `halt` or a cycle limit, and reports the outcome. Sits directly upstream of `comp`: drives its `oob_*` inputs and its reset, and observes its `halt`.

## Interface
- `ADDR_W`, 8: program word address width; maximum load is 2^ADDR_W words.
- `MAX_CYCLES`, 100: run-cycle limit before timeout. Must be ≥ 1.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `start`  input  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- `load_len`  input  ADDR_W+1  number of words to load (0..2^ADDR_W); sampled on accepted `start`.
- `in_data`  input  32  program word.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  loader accepts a word this cycle.
- `oob_wr_addr`  output  32  write address to `comp`; zero-extended word index.
- `oob_wr_data`  output  32  write data to `comp`.
- `oob_wen`  output  1  write strobe to `comp`.
- `cpu_rst`  output  1  reset to `comp`, active-high.
- `halt`  input  1  `comp` halt indication.
- `busy`  output  1  high in LOAD, SETTLE and RUN.
- `done`  output  1  high in DONE.
- `timed_out`  output  1  valid while `done`; 1 = limit reached without halt.
- `run_cycles`  output  32  number of cycles spent in RUN.

## Operation
- States: IDLE, LOAD, SETTLE, RUN, DONE.
- Reset values: state IDLE; `in_ready`=0, `oob_wen`=0, `oob_wr_addr`=0, `oob_wr_data`=0, `cpu_rst`=1, `busy`=0, `done`=0, `timed_out`=0, `run_cycles`=0. The internal word counter resets to 0.
- IDLE/DONE + `start`:
  - Latch `load_len`.
  - Clear the word counter, `done`, `timed_out` and `run_cycles`.
  - Assert `cpu_rst`.
  - Go to LOAD. If `load_len`=0, go to SETTLE instead.
- LOAD:
  - `in_ready`=1, combinationally from state.
  - Each `in_valid & in_ready` edge is one accepted word. It registers `oob_wr_addr`=counter, `oob_wr_data`=`in_data` and `oob_wen`=1 for exactly the following cycle; the counter then increments.
  - `oob_wen` is 0 in any cycle following a cycle with no accept.
  - When the accept brings the counter to `load_len`, go to SETTLE.
  - `in_valid` low stalls indefinitely; there is no timeout during load.
- SETTLE:
  - Lasts exactly one cycle, with `in_ready`=0 and `cpu_rst`=1.
  - The last word's `oob_wen` pulse falls in this cycle, so `comp` captures it while still in reset.
  - Go to RUN; `cpu_rst`=0 from the first RUN cycle.
- RUN:
  - `run_cycles` increments every cycle.
  - `halt`=1 sampled at an edge: go to DONE with `timed_out`=0.
  - Otherwise, when the increment makes `run_cycles` equal `MAX_CYCLES`: go to DONE with `timed_out`=1.
  - If halt and the limit coincide, halt wins and `timed_out`=0.
- DONE:
  - `done`=1, `cpu_rst` stays 0, and `run_cycles` is frozen.
  - `start` begins a new load.
- `start` in LOAD, SETTLE or RUN is ignored. `in_valid` outside LOAD is ignored, since `in_ready`=0 there.
- Async reset mid-operation: return immediately to reset values. A partially loaded program is abandoned and `comp` is held in reset.
- Address arithmetic: the counter is ADDR_W+1 bits. `load_len`=2^ADDR_W writes addresses 0..2^ADDR_W−1 with no wrap.

## Timing
- Load latency: a word accepted at edge k has `oob_wen`=1 between edges k and k+1.
- Back-to-back accepts give a continuous `oob_wen` run, one address per cycle.
- Total load time: N accept cycles + 1 SETTLE cycle before `cpu_rst` falls.
- Halt response: `halt` first high before edge t gives `done`=1 after edge t, with `run_cycles` including cycle t.
- All outputs are registered except `in_ready`, `busy` and `done`, which are decoded from state.

## Test plan
- Reset, then `start` with `load_len`=4 and words 0xA0..0xA3 streamed every cycle:
  - `oob_wen` is high for 4 consecutive cycles with addr 0..3 and data A0..A3.
  - SETTLE follows for 1 cycle, then `cpu_rst` falls.
- Same load with `in_valid` toggling 1,0,1,0:
  - Exactly 4 `oob_wen` pulses, each one cycle, at addr 0..3 in order.
  - No write occurs in gap cycles.
- Run with `halt` asserted on the 7th RUN cycle: `done`=1, `timed_out`=0, `run_cycles`=7.
- Run with `MAX_CYCLES`=100 and `halt` never asserted: `done`=1, `timed_out`=1, `run_cycles`=100.
- Run where `halt` rises on cycle 100: `timed_out`=0.
- `load_len`=0: no `oob_wen` pulse, one SETTLE cycle, then RUN.
- `start` pulsed during RUN is ignored.
- `rst` driven low mid-LOAD after 2 words:
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - A subsequent `start` writes from addr 0 again.
